// File: rtl/bp_fpga_host_pkg.sv
// Shared NBF definitions for the FPGA host UART link (transmit and receive ends).
// Contents: NBF packet layout, packet byte count, packet-level and
// character-level transmitter state encodings.
package bp_fpga_host_pkg;

    localparam int unsigned nbf_bytes_gp = 14;
    localparam int unsigned nbf_width_gp = 8 * nbf_bytes_gp;

    // Opcode in the MSBs; data occupies the low 8 bytes so it goes out first.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [39:0] addr;
        logic [63:0] data;
    } bp_fpga_host_nbf_s;

    typedef enum logic {
        e_ready,
        e_send
    } nbf_tx_state_e;

    typedef enum logic [2:0] {
        e_idle,
        e_start,
        e_data,
        e_parity,
        e_stop
    } uart_tx_state_e;

endpackage

// File: rtl/bp_fpga_host_nbf_tx_if.sv
// NBF packet ready/valid port.
//   nbf_i           : packet {opcode, addr, data}
//   nbf_v_i         : packet valid (from producer)
//   nbf_ready_and_o : ready to accept (from transmitter)
// master = packet producer, slave = transmitter.
interface bp_fpga_host_nbf_tx_if;
    import bp_fpga_host_pkg::*;

    bp_fpga_host_nbf_s nbf_i;
    logic              nbf_v_i;
    logic              nbf_ready_and_o;

    modport master (output nbf_i, output nbf_v_i, input nbf_ready_and_o);
    modport slave  (input nbf_i, input nbf_v_i, output nbf_ready_and_o);
endinterface

// File: rtl/bp_fpga_host_uart_tx.sv
// UART character transmitter: start bit, data bits LSB first, optional parity,
// 1 or 2 stop bits, each bit held clk_per_bit_p cycles.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   byte_i, v_i      : byte to send and its valid
//   ready_and_o      : byte accepted when v_i & ready_and_o
//   done_o           : last cycle of the final stop bit of the current byte
//   tx_o             : registered serial line, idle high
module bp_fpga_host_uart_tx
    import bp_fpga_host_pkg::*;
#(
    parameter int unsigned clk_per_bit_p = 10416,
    parameter int unsigned data_bits_p   = 8,
    parameter int unsigned parity_bit_p  = 0,
    parameter int unsigned parity_odd_p  = 0,
    parameter int unsigned stop_bits_p   = 1
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [7:0] byte_i,
    input  logic       v_i,
    output logic       ready_and_o,
    output logic       done_o,
    output logic       tx_o
);

    localparam int unsigned baud_w_lp = (clk_per_bit_p > 1) ? $clog2(clk_per_bit_p) : 1;
    localparam logic [baud_w_lp-1:0] baud_last_lp = baud_w_lp'(clk_per_bit_p - 1);
    localparam logic [2:0] bit_last_lp  = 3'(data_bits_p - 1);
    localparam logic       stop_last_lp = (stop_bits_p == 2);

    uart_tx_state_e       state_q, state_d;
    logic [baud_w_lp-1:0] baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [7:0]           shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;

    logic bit_end, last_stop, accept;

    assign bit_end     = (baud_q == baud_last_lp);
    assign last_stop   = (state_q == e_stop) && bit_end && (stop_q == stop_last_lp);
    assign done_o      = last_stop;
    // Accepting in the final stop cycle lets bytes run with no idle gap.
    assign ready_and_o = (state_q == e_idle) || last_stop;
    assign accept      = v_i & ready_and_o;
    assign tx_o        = tx_q;

    always_comb begin
        state_d  = state_q;
        baud_d   = bit_end ? '0 : baud_q + baud_w_lp'(1);
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        case (state_q)
            e_idle: begin
                baud_d = '0;
                tx_d   = 1'b1;
            end
            e_start: if (bit_end) begin
                state_d = e_data;
                bit_d   = '0;
                tx_d    = shift_q[0];
            end
            e_data: if (bit_end) begin
                if (bit_q == bit_last_lp) begin
                    if (parity_bit_p != 0) begin
                        state_d = e_parity;
                        tx_d    = parity_q;
                    end else begin
                        state_d = e_stop;
                        stop_d  = 1'b0;
                        tx_d    = 1'b1;
                    end
                end else begin
                    // shift_q[0] always holds the bit currently on the line
                    bit_d   = bit_q + 3'd1;
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                end
            end
            e_parity: if (bit_end) begin
                state_d = e_stop;
                stop_d  = 1'b0;
                tx_d    = 1'b1;
            end
            e_stop: if (bit_end) begin
                if (stop_q == stop_last_lp) begin
                    state_d = e_idle;
                    tx_d    = 1'b1;
                end else begin
                    stop_d = 1'b1;
                end
            end
            default: state_d = e_idle;
        endcase
        if (accept) begin
            state_d  = e_start;
            baud_d   = '0;
            shift_d  = byte_i;
            parity_d = (parity_odd_p != 0) ? ~^byte_i : ^byte_i;
            tx_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= e_idle;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/bp_fpga_host_nbf_tx.sv
// NBF packet transmitter: takes whole 14-byte NBF packets on a ready/valid port
// and sends them over UART, byte 0 (data LSB) first, opcode last.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   nbf_if (slave)   : nbf_i / nbf_v_i / nbf_ready_and_o packet port
//   tx_o             : UART line, idle high
//   busy_o           : packet in flight
//   packets_sent_o   : completed-packet count, only with BP_FPGA_HOST_NBF_TX_STATS_EN
module bp_fpga_host_nbf_tx
    import bp_fpga_host_pkg::*;
#(
    parameter int unsigned nbf_addr_width_p   = 40,
    parameter int unsigned nbf_data_width_p   = 64,
    parameter int unsigned uart_clk_per_bit_p = 10416,
    parameter int unsigned uart_data_bits_p   = 8,
    parameter int unsigned uart_parity_bit_p  = 0,
    parameter int unsigned uart_parity_odd_p  = 0,
    parameter int unsigned uart_stop_bits_p   = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bp_fpga_host_nbf_tx_if.slave  nbf_if,
    output logic                  tx_o,
    output logic                  busy_o
`ifdef BP_FPGA_HOST_NBF_TX_STATS_EN
    ,
    output logic [31:0]           packets_sent_o
`endif
);

    localparam int unsigned nbf_width_lp = 8 + nbf_addr_width_p + nbf_data_width_p;
    localparam logic [3:0]  idx_last_lp  = 4'(nbf_bytes_gp - 1);

    nbf_tx_state_e           state_q, state_d;
    logic [nbf_width_lp-1:0] shift_q, shift_d;
    logic [3:0]              idx_q, idx_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;

    logic       accept, pkt_done;
    logic       byte_v, byte_ready, byte_done;
    logic [7:0] byte_li;

    assign accept                 = nbf_if.nbf_v_i & ready_q;
    assign pkt_done               = (state_q == e_send) && (idx_q == idx_last_lp) && byte_done;
    assign nbf_if.nbf_ready_and_o = ready_q;
    assign busy_o                 = busy_q;

    // Byte 0 goes straight from the port to the UART on the accept edge, so
    // the start bit appears the cycle after the handshake; shift_q[7:0] then
    // tracks the byte on the line and shift_q[15:8] is the next one.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        byte_v  = 1'b0;
        byte_li = shift_q[7:0];
        case (state_q)
            e_ready: begin
                byte_v  = accept;
                byte_li = nbf_if.nbf_i[7:0];
                ready_d = 1'b1;
                if (accept) begin
                    state_d = e_send;
                    shift_d = nbf_if.nbf_i;
                    idx_d   = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            e_send: begin
                byte_v  = (idx_q != idx_last_lp);
                byte_li = shift_q[15:8];
                if (byte_v && byte_ready) begin
                    shift_d = shift_q >> 8;
                    idx_d   = idx_q + 4'd1;
                end
                if (pkt_done) begin
                    state_d = e_ready;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_ready;
            shift_q <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    bp_fpga_host_uart_tx #(
        .clk_per_bit_p (uart_clk_per_bit_p),
        .data_bits_p   (uart_data_bits_p),
        .parity_bit_p  (uart_parity_bit_p),
        .parity_odd_p  (uart_parity_odd_p),
        .stop_bits_p   (uart_stop_bits_p)
    ) uart_tx (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .byte_i      (byte_li),
        .v_i         (byte_v),
        .ready_and_o (byte_ready),
        .done_o      (byte_done),
        .tx_o        (tx_o)
    );

`ifdef BP_FPGA_HOST_NBF_TX_STATS_EN
    logic [31:0] sent_q, sent_d;

    always_comb sent_d = sent_q + {31'd0, pkt_done};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) sent_q <= '0;
        else            sent_q <= sent_d;
    end

    assign packets_sent_o = sent_q;
`endif

endmodule
